uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  8N1 UART receiver with 16x oversampling feeding a byte FIFO. Sits between the board rx pin
//  and the J1 core's I/O read port inside papilio_pro_j1. Serial bytes are queued until the
//  core pops them. Framing and overrun errors are reported as sticky flags.
// PARAMETERS
//  CLK_HZ      32_000_000  system clock frequency
//  BAUD        115_200     line rate; TICK_DIV = CLK_HZ/(16*BAUD), integer floor, must be >= 1
//  DEPTH_LOG2  4           FIFO depth = 2**DEPTH_LOG2 entries of 8 bits
// PORTS
//  sys_clk_i    in   1             system clock; all logic on its rising edge
//  sys_rst_i    in   1             synchronous reset, active-high
//  rx_i         in   1             asynchronous serial input; idle high
//  rd_i         in   1             pop head byte; one-cycle pulse
//  err_clr_i    in   1             clear frame_err_o and overrun_o
//  data_o       out  8             FIFO head (first-word-fall-through); 0 when empty
//  avail_o      out  1             FIFO not empty
//  count_o      out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
//  busy_o       out  1             receiver FSM not in IDLE
//  frame_err_o  out  1             sticky: stop bit sampled low
//  overrun_o    out  1             sticky: byte completed while FIFO full
// BEHAVIOUR
//  Reset: data_o=0, avail_o=0, count_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
//   Both sync flops=1, FSM=IDLE, tick and bit counters=0, FIFO pointers=0.
//   Reset mid-frame aborts the frame; no partial byte is pushed.
//  Input sync: rx_i passes through 2 flops to give rxs. rxs alone drives the FSM.
//  Tick gen: counter 0..TICK_DIV-1. tick = 1-cycle pulse on wrap. Counter runs freely.
//   Sample counter s (0..15) advances on each tick and is zeroed on every state entry.
//  FSM:
//   IDLE  : rxs==0 -> START (s=0).
//   START : at s==7, rxs==0 -> DATA (s=0, bit=0). rxs==1 -> IDLE (glitch rejected, no flag).
//   DATA  : at s==15, shift rxs into shreg LSB-first and increment bit.
//           After bit 7 -> STOP.
//   STOP  : at s==15, sample rxs.
//           rxs==1 -> push shreg, then IDLE.
//           rxs==0 -> set frame_err_o, drop byte, go to BREAK.
//   BREAK : wait for rxs==1, then IDLE. A held-low line yields exactly one error.
//  Resulting sample points: mid-bit of each bit, 8+16k ticks after the start edge.
//  Push latency: avail_o/count_o update the cycle after the STOP sample cycle.
//  FIFO: circular, pointers wrap mod 2**DEPTH_LOG2.
//   Pop on empty: ignored, no flag.
//   Push on full without a pop: byte dropped, overrun_o set.
//   Push and pop in the same cycle while full: both accepted, count unchanged, no overrun.
//   Push and pop in the same cycle while empty: push only.
//   data_o shows the new head the cycle after a pop.
//  Flags: err_clr_i clears both flags. A set in the same cycle as err_clr_i wins (flag stays 1).
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE/START/DATA/STOP/BREAK), tick_div(CLK_HZ,BAUD) function.
//   Shared with the future uart_tx.
//  Sub-module sync_fifo #(W=8, DEPTH_LOG2): FWFT, push/pop/full/empty/count.
//   Owns the simultaneous push+pop rules above.
//  Top level holds: synchroniser, tick generator, FSM, shift register, flags.
// TESTING (CLK_HZ=3_200_000, BAUD=100_000 -> TICK_DIV=2, 32 clk/bit)
//  1. Send 0xA5 8N1 -> avail_o=1 with data_o=0xA5 within 330 clk of the start edge.
//     count_o=1; rd_i pulse -> avail_o=0, data_o=0.
//  2. Low pulse of 8 clk on idle line -> busy_o returns 0; count_o=0; frame_err_o=0.
//  3. Send 0x3C with stop bit low -> frame_err_o=1, count_o=0.
//     Hold line low 100 clk -> flag set once, FSM stays in BREAK.
//     Release line, err_clr_i -> frame_err_o=0.
//  4. Send 17 bytes 0x00..0x10 with no reads -> count_o=16, overrun_o=1.
//     16 pops return 0x00..0x0F in order.
//  5. Fill FIFO to 16, pulse rd_i on the push cycle of a 17th byte -> overrun_o=0, count_o=16.
//  6. Assert sys_rst_i during DATA bit 4 -> all outputs at reset values next cycle.
//     Next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding and baud-divider helper shared by rx and tx
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through circular FIFO; a pop frees space for a same-cycle push
module sync_fifo #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [W-1:0]          push_data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [W-1:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver, 16x oversampled, queueing bytes into a FWFT FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 32_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  rx_i,
  input  logic                  rd_i,
  input  logic                  err_clr_i,
  output logic [7:0]            data_o,
  output logic                  avail_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);
  localparam int unsigned TICK_DIV = tick_div(CLK_HZ, BAUD);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic            rx_meta_q, rxs_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  uart_state_e     state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            push, ferr_set, ovr_set;
  logic            fifo_empty, fifo_full;
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    s_d      = tick ? s_q + 4'd1 : s_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick && s_q == 4'd7) begin
          s_d     = '0;
          bit_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && s_q == 4'd15) begin
          s_d     = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && s_q == 4'd15) begin
          s_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Held-low line stays here so a long break reports a single error.
        if (rxs_q) begin
          state_d = ST_IDLE;
          s_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
    endcase
  end

  // Full FIFO always accepts a pop, so a concurrent rd_i makes room for the push.
  assign ovr_set     = push && fifo_full && !rd_i;
  assign frame_err_d = ferr_set || (frame_err_q && !err_clr_i);
  assign overrun_d   = ovr_set || (overrun_q && !err_clr_i);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tick_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rxs_q       <= rx_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .W          (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i       (sys_clk_i),
    .rst_i       (sys_rst_i),
    .push_i      (push),
    .push_data_i (shreg_q),
    .pop_i       (rd_i),
    .data_o      (data_o),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (count_o)
  );

  assign avail_o     = !fifo_empty;
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       avail;
  logic [4:0] count;
  logic       busy, ferr, ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr  = 1'b0;
  logic       exp_ferr = 1'b0;

  uart_rx_fifo #(
    .CLK_HZ     (3_200_000),
    .BAUD       (100_000),
    .DEPTH_LOG2 (4)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .rx_i        (rx),
    .rd_i        (rd),
    .err_clr_i   (clr),
    .data_o      (data),
    .avail_o     (avail),
    .count_o     (count),
    .busy_o      (busy),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  // Index of the latest rising edge since reset release; the tick fires on even edges.
  always @(posedge clk) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if (exp_q.size() < 16) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // 32 clk per bit; leaves the line at the stop level.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(32);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(32);
    end
    rx = stop;
    step(32);
  endtask

  task automatic send(input logic [7:0] b);
    drive_frame(b, 1'b1);
    rx = 1'b1;
    model_frame(b, 1'b1);
  endtask

  task automatic pop();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    n_checks++;
    if ({data, avail, count, busy, ferr, ovr} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%0h avail=%0b count=%0d busy=%0b ferr=%0b ovr=%0b, want all 0", data, avail, count, busy, ferr, ovr);
    end
  endtask

  task automatic test_single_byte();
    send(8'hA5);
    n_checks++;
    if (avail !== 1'b1 || data !== 8'hA5) begin
      n_fail++; $display("FAIL single_head: got avail=%0b data=%0h want 1/a5", avail, data);
    end
    n_checks++;
    if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    pop();
    n_checks++;
    if (avail !== 1'b0 || data !== 8'h00 || count !== 5'd0) begin
      n_fail++; $display("FAIL single_pop: got avail=%0b data=%0h count=%0d want 0/0/0", avail, data, count);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    step(8);
    rx = 1'b1;
    step(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_during: got %0b want 1", busy); end
    step(40);
    n_checks++;
    if (busy !== 1'b0 || count !== 5'd0 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject: got busy=%0b count=%0d ferr=%0b want 0/0/0", busy, count, ferr);
    end
  endtask

  task automatic test_frame_error();
    drive_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    n_checks++;
    if (ferr !== exp_ferr || count !== 5'(exp_q.size())) begin
      n_fail++; $display("FAIL ferr_set: got ferr=%0b count=%0d want %0b/%0d", ferr, count, exp_ferr, exp_q.size());
    end
    step(100);
    n_checks++;
    if (busy !== 1'b1 || ferr !== 1'b1) begin
      n_fail++; $display("FAIL ferr_break_hold: got busy=%0b ferr=%0b want 1/1", busy, ferr);
    end
    pulse_clr();
    step(100);
    n_checks++;
    if (ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_single_error: got %0b want 0", ferr); end
    rx = 1'b1;
    step(4);
    n_checks++;
    if (busy !== 1'b0 || ferr !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL ferr_release: got busy=%0b ferr=%0b count=%0d want 0/0/0", busy, ferr, count);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] b;
    int         npop;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send(b);
      n_checks++;
      if (count !== 5'(exp_q.size()) || data !== exp_head()) begin
        n_fail++; $display("FAIL rand_after_rx[%0d]: got count=%0d data=%0h want %0d/%0h", i, count, data, exp_q.size(), exp_head());
      end
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        pop();
        n_checks++;
        if (count !== 5'(exp_q.size()) || data !== exp_head() || avail !== (exp_q.size() > 0)) begin
          n_fail++; $display("FAIL rand_pop[%0d.%0d]: got count=%0d data=%0h avail=%0b want %0d/%0h", i, j, count, data, avail, exp_q.size(), exp_head());
        end
      end
    end
    while (exp_q.size() > 0) begin
      pop();
      n_checks++;
      if (count !== 5'(exp_q.size()) || data !== exp_head()) begin
        n_fail++; $display("FAIL rand_drain: got count=%0d data=%0h want %0d/%0h", count, data, exp_q.size(), exp_head());
      end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i <= 16; i++) send(8'(i));
    n_checks++;
    if (count !== 5'd16 || ovr !== exp_ovr || exp_ovr !== 1'b1) begin
      n_fail++; $display("FAIL ovr_full: got count=%0d ovr=%0b want 16/1", count, ovr);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (data !== exp_head() || data !== 8'(i)) begin
        n_fail++; $display("FAIL ovr_order[%0d]: got %0h want %0h", i, data, 8'(i));
      end
      pop();
    end
    n_checks++;
    if (avail !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL ovr_drained: got avail=%0b count=%0d want 0/0", avail, count);
    end
    pulse_clr();
    n_checks++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b want 0", ovr); end
  endtask

  task automatic test_pop_on_full();
    logic [7:0] b;
    int         first_tick, push_edge;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    n_checks++;
    if (count !== 5'd16 || ovr !== 1'b0) begin
      n_fail++; $display("FAIL pof_fill: got count=%0d ovr=%0b want 16/0", count, ovr);
    end
    b = 8'($urandom);
    // Start detected 3 edges after the line falls; stop sampled on the 152nd tick after that.
    first_tick = ((n_edge + 4) % 2 == 0) ? n_edge + 4 : n_edge + 5;
    push_edge  = first_tick + 2 * 151;
    fork
      begin
        drive_frame(b, 1'b1);
        rx = 1'b1;
      end
      begin
        while (n_edge < push_edge - 1) step(1);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(b);
    n_checks++;
    if (count !== 5'd16 || ovr !== 1'b0 || data !== exp_head()) begin
      n_fail++; $display("FAIL pof_same_cycle: got count=%0d ovr=%0b data=%0h want 16/0/%0h", count, ovr, data, exp_head());
    end
    while (exp_q.size() > 0) begin
      n_checks++;
      if (data !== exp_head()) begin
        n_fail++; $display("FAIL pof_drain: got %0h want %0h", data, exp_head());
      end
      pop();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    send(8'h77);
    pulse_clr();
    b = 8'($urandom);
    rx = 1'b0;
    step(32);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      step(32);
    end
    rx = b[4];
    step(10);
    n_checks++;
    if (busy !== 1'b1 || count !== 5'd1) begin
      n_fail++; $display("FAIL rst_mid_pre: got busy=%0b count=%0d want 1/1", busy, count);
    end
    rst = 1'b1;
    rx  = 1'b1;
    step(1);
    exp_q.delete();
    n_checks++;
    if ({data, avail, count, busy, ferr, ovr} !== 17'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got data=%0h avail=%0b count=%0d busy=%0b ferr=%0b ovr=%0b want all 0", data, avail, count, busy, ferr, ovr);
    end
    rst = 1'b0;
    step(5);
    send(8'h5A);
    n_checks++;
    if (count !== 5'd1 || data !== 8'h5A || avail !== 1'b1 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_next: got count=%0d data=%0h avail=%0b ferr=%0b want 1/5a/1/0", count, data, avail, ferr);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_random_traffic();
    test_overrun();
    test_pop_on_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
